seq_divider_8: RTL and testbench

Multi-cycle restoring integer divider. It is the inverse-direction companion to the 8-bit Booth multiplier in the CNN datapath. Used for average-pooling normalisation and requantisation scaling. It accepts one dividend/divisor pair through a valid/ready handshake, iterates one quotient bit per clock, and presents quotient and remainder through a second valid/ready handshake.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_restoring_step.sv | 24 ++
 rtl/seq_divider_8.sv | 137 +++++++++++++
 tb/tb_seq_divider_8.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and helpers for the sequential restoring divider
package div_pkg;

    typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 8;
    localparam int DIV_CNT_W         = $clog2(DIV_DEFAULT_WIDTH + 1);

    // Counter width able to hold the value w (iteration count) for a given operand width.
    function automatic int div_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Two's-complement magnitude; the most-negative value maps to itself, which is
    // the correct unsigned magnitude once truncated back to the operand width.
    function automatic logic [31:0] abs_val(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_restoring_step.sv
// rtl/div_restoring_step.sv - one combinational restoring-division iteration
module div_restoring_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    assign trial = {p_i, q_i[WIDTH-1]};
    assign fits  = (trial >= {1'b0, d_i});
    assign diff  = trial - {1'b0, d_i};

    // Partial remainder is always below the divisor, so the top bit is dropped safely.
    assign p_o = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign q_o = {q_i[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider_8.sv
// rtl/seq_divider_8.sv - multi-cycle restoring divider with valid/ready in and out
module seq_divider_8
    import div_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_quo_q, sgn_quo_d;
    logic             sgn_rem_q, sgn_rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic signed [WIDTH-1:0] dvd_s, dvs_s;
    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] step_p, step_a;

    assign dvd_s   = dividend;
    assign dvs_s   = divisor;
    assign dvd_neg = SIGNED && dividend[WIDTH-1];
    assign dvs_neg = SIGNED && divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? WIDTH'(abs_val(32'(dvd_s))) : dividend;
    assign dvs_mag = dvs_neg ? WIDTH'(abs_val(32'(dvs_s))) : divisor;

    div_restoring_step #(.WIDTH(WIDTH)) u_step (
        .p_i (p_q),
        .q_i (a_q),
        .d_i (b_q),
        .p_o (step_p),
        .q_o (step_a)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_quo_d = sgn_quo_q;
        sgn_rem_d = sgn_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        case (state_q)
            DIV_IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        state_d = DIV_DONE;
                        quo_d   = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d   = DIV_BUSY;
                        cnt_d     = CNT_W'(WIDTH);
                        p_d       = '0;
                        a_d       = dvd_mag;
                        b_d       = dvs_mag;
                        sgn_quo_d = dvd_neg ^ dvs_neg;
                        sgn_rem_d = dvd_neg;
                    end
                end
            end
            DIV_BUSY: begin
                p_d   = step_p;
                a_d   = step_a;
                cnt_d = cnt_q - CNT_W'(1);
                // Final iteration: sign-correct straight from the step outputs.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DIV_DONE;
                    quo_d   = sgn_quo_q ? (~step_a + WIDTH'(1)) : step_a;
                    rem_d   = sgn_rem_q ? (~step_p + WIDTH'(1)) : step_p;
                    dbz_d   = 1'b0;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_d = DIV_IDLE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            p_q       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sgn_quo_q <= sgn_quo_d;
            sgn_rem_q <= sgn_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign in_ready    = (state_q == DIV_IDLE);
    assign out_valid   = (state_q == DIV_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_8.sv
// tb/tb_seq_divider_8.sv - directed self-checking bench for seq_divider_8
module tb_seq_divider_8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;

    logic       ir_u, ov_u, dz_u;
    logic [7:0] q_u, r_u;
    logic       ir_s, ov_s, dz_s;
    logic [7:0] q_s, r_s;

    int n_checks = 0;
    int n_fail   = 0;
    bit watch_ov = 1'b0;
    bit ov_seen  = 1'b0;

    always #5 clk = ~clk;

    seq_divider_8 #(.WIDTH(8), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_u),
        .dividend(dividend), .divisor(divisor), .out_valid(ov_u), .out_ready(out_ready),
        .quotient(q_u), .remainder(r_u), .div_by_zero(dz_u)
    );

    seq_divider_8 #(.WIDTH(8), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s),
        .dividend(dividend), .divisor(divisor), .out_valid(ov_s), .out_ready(out_ready),
        .quotient(q_s), .remainder(r_s), .div_by_zero(dz_s)
    );

    always @(negedge clk) begin
        if (watch_ov && (ov_u || ov_s)) ov_seen = 1'b1;
    end

    typedef struct {
        logic [7:0] dvd;
        logic [7:0] dvs;
        bit         sel;
        logic [7:0] q;
        logic [7:0] r;
        bit         dz;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic ov_sel(input bit sel);
        return sel ? ov_s : ov_u;
    endfunction

    task automatic run_op(input vec_t v, input int idx);
        int         n;
        logic [7:0] qa, ra;
        logic       dza, ira;
        @(negedge clk);
        dividend = v.dvd;
        divisor  = v.dvs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        n = 0;
        while (!ov_sel(v.sel) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("vec%0d latency", idx), n, (v.dvs == 8'd0) ? 0 : 8);
        qa  = v.sel ? q_s  : q_u;
        ra  = v.sel ? r_s  : r_u;
        dza = v.sel ? dz_s : dz_u;
        check($sformatf("vec%0d quotient", idx), qa, v.q);
        check($sformatf("vec%0d remainder", idx), ra, v.r);
        check($sformatf("vec%0d div_by_zero", idx), dza, v.dz);
        @(posedge clk);
        #1;
        ira = v.sel ? ir_s : ir_u;
        check($sformatf("vec%0d in_ready after handshake", idx), ira, 1'b1);
        qa  = v.sel ? q_s : q_u;
        check($sformatf("vec%0d quotient retained", idx), qa, v.q);
    endtask

    vec_t vecs [10];

    initial begin
        vecs[0] = '{dvd: 8'd200, dvs: 8'd7,   sel: 1'b0, q: 8'd28,  r: 8'd4,  dz: 1'b0};
        vecs[1] = '{dvd: 8'd255, dvs: 8'd1,   sel: 1'b0, q: 8'd255, r: 8'd0,  dz: 1'b0};
        vecs[2] = '{dvd: 8'd0,   dvs: 8'd5,   sel: 1'b0, q: 8'd0,   r: 8'd0,  dz: 1'b0};
        vecs[3] = '{dvd: 8'd7,   dvs: 8'd200, sel: 1'b0, q: 8'd0,   r: 8'd7,  dz: 1'b0};
        vecs[4] = '{dvd: 8'd5,   dvs: 8'd0,   sel: 1'b0, q: 8'hFF,  r: 8'd5,  dz: 1'b1};
        vecs[5] = '{dvd: 8'd100, dvs: 8'd10,  sel: 1'b0, q: 8'd10,  r: 8'd0,  dz: 1'b0};
        vecs[6] = '{dvd: 8'h9C,  dvs: 8'h07,  sel: 1'b1, q: 8'hF2,  r: 8'hFE, dz: 1'b0};
        vecs[7] = '{dvd: 8'h64,  dvs: 8'hF9,  sel: 1'b1, q: 8'hF2,  r: 8'h02, dz: 1'b0};
        vecs[8] = '{dvd: 8'h80,  dvs: 8'hFF,  sel: 1'b1, q: 8'h80,  r: 8'h00, dz: 1'b0};
        vecs[9] = '{dvd: 8'hFD,  dvs: 8'h00,  sel: 1'b1, q: 8'hFF,  r: 8'hFD, dz: 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        dividend  = 8'd0;
        divisor   = 8'd0;
        #1;
        check("reset in_ready", {ir_u, ir_s}, 2'b11);
        check("reset out_valid", {ov_u, ov_s}, 2'b00);
        check("reset quotient", {q_u, q_s}, 16'h0);
        check("reset remainder", {r_u, r_s}, 16'h0);
        check("reset div_by_zero", {dz_u, dz_s}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i], i);

        // Backpressure with stray in_valid during BUSY/DONE.
        begin
            int n;
            out_ready = 1'b0;
            @(negedge clk);
            dividend = 8'd90;
            divisor  = 8'd4;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            dividend = 8'd1;
            divisor  = 8'd1;
            n = 0;
            while (!ov_u && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("bp latency", n, 8);
            check("bp quotient", q_u, 8'd22);
            check("bp remainder", r_u, 8'd2);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                check($sformatf("bp hold%0d out_valid", c), ov_u, 1'b1);
                check($sformatf("bp hold%0d in_ready", c), ir_u, 1'b0);
                check($sformatf("bp hold%0d q/r", c), {q_u, r_u}, {8'd22, 8'd2});
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("bp release out_valid", ov_u, 1'b0);
            check("bp release in_ready", ir_u, 1'b1);
            @(posedge clk);
            #1;
            check("bp idle stays idle", ir_u, 1'b1);
        end

        // Reset three cycles into 85/30.
        @(negedge clk);
        dividend = 8'd85;
        divisor  = 8'd30;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        watch_ov = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid reset in_ready", {ir_u, ir_s}, 2'b11);
        check("mid reset out_valid", {ov_u, ov_s}, 2'b00);
        check("mid reset quotient", q_u, 8'd0);
        check("mid reset remainder", r_u, 8'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        watch_ov = 1'b0;
        check("mid reset no out_valid pulse", ov_seen, 1'b0);
        run_op('{dvd: 8'd85, dvs: 8'd30, sel: 1'b0, q: 8'd2, r: 8'd25, dz: 1'b0}, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
